// File: rtl/burst_rd_responder.sv
// burst_rd_responder
//   Memory-side responder for cache line refills. It accepts one line-aligned
//   read request, waits REQ_LATENCY idle cycles, then returns BURST_LEN 32-bit
//   beats with a last flag. The data comes from an internal word-addressed
//   array that is preloaded through a simple write port.
//
//   Optional feature macro: BURST_BUBBLE_EN. When it is defined, rsp_valid
//   drops for one cycle after every accepted non-last beat.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   from_cache_rd_req_valid  read request valid
//   from_cache_rd_req_addr   request byte address (offset-in-line bits ignored)
//   to_cache_rd_req_ready    request can be accepted (IDLE only)
//   to_cache_rd_rsp_valid    current beat valid
//   to_cache_rd_rsp_data     current beat data
//   to_cache_rd_rsp_last     current beat is the final beat of the burst
//   from_cache_rd_rsp_ready  cache accepts the current beat
//   init_wen/addr/wdata      preload write port (word address)
module burst_rd_responder #(
    parameter int MEM_AW      = 10,
    parameter int BURST_LEN   = 8,
    parameter int REQ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              from_cache_rd_req_valid,
    input  logic [31:0]       from_cache_rd_req_addr,
    output logic              to_cache_rd_req_ready,
    output logic              to_cache_rd_rsp_valid,
    output logic [31:0]       to_cache_rd_rsp_data,
    output logic              to_cache_rd_rsp_last,
    input  logic              from_cache_rd_rsp_ready,
    input  logic              init_wen,
    input  logic [MEM_AW-1:0] init_addr,
    input  logic [31:0]       init_wdata
);

    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int OFF_W  = $clog2(BURST_LEN * 4);
    localparam int LINE_W = MEM_AW - BEAT_W;

    localparam logic [BEAT_W-1:0] BEAT_ZERO = '0;
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [3:0]        LAT_INIT  = 4'(REQ_LATENCY);

`ifdef BURST_BUBBLE_EN
    localparam logic BUBBLE = 1'b1;
`else
    localparam logic BUBBLE = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LAT  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [BEAT_W-1:0] beat_r, beat_s, beat_inc_s;
    logic [3:0]        lat_r, lat_s;
    logic [LINE_W-1:0] line_r, line_s, req_line_s;
    logic [31:0]       data_r, data_s;
    logic              valid_r, valid_s;
    logic              last_r, last_s;
    logic              ready_r, ready_s;

    logic [31:0]       mem_r [0:(1<<MEM_AW)-1];

    // Line index: bits above the in-line offset, upper bits dropped so that
    // addresses beyond the storage alias modulo its size.
    assign req_line_s = from_cache_rd_req_addr[MEM_AW+1:OFF_W];
    assign beat_inc_s = beat_r + BEAT_ONE;

    // Next-state and next-output logic for the IDLE -> LAT -> SEND -> IDLE flow
    always_comb begin
        state_s = state_r;
        beat_s  = beat_r;
        lat_s   = lat_r;
        line_s  = line_r;
        data_s  = data_r;
        valid_s = valid_r;
        last_s  = last_r;
        ready_s = ready_r;
        case (state_r)
            ST_IDLE: begin
                ready_s = 1'b1;
                if (from_cache_rd_req_valid && ready_r) begin
                    line_s  = req_line_s;
                    beat_s  = BEAT_ZERO;
                    lat_s   = LAT_INIT;
                    ready_s = 1'b0;
                    if (LAT_INIT == 4'd0) begin
                        // Zero latency: first beat is loaded on the accept edge.
                        state_s = ST_SEND;
                        data_s  = mem_r[{req_line_s, BEAT_ZERO}];
                        valid_s = 1'b1;
                        last_s  = (BEAT_LAST == BEAT_ZERO);
                    end else begin
                        state_s = ST_LAT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAT: begin
                ready_s = 1'b0;
                if (lat_r <= 4'd1) begin
                    state_s = ST_SEND;
                    lat_s   = 4'd0;
                    data_s  = mem_r[{line_r, BEAT_ZERO}];
                    valid_s = 1'b1;
                    last_s  = (BEAT_LAST == BEAT_ZERO);
                end else begin
                    lat_s = lat_r - 4'd1;
                end
            end
            ST_SEND: begin
                ready_s = 1'b0;
                if (valid_r) begin
                    if (from_cache_rd_rsp_ready) begin
                        if (last_r) begin
                            state_s = ST_IDLE;
                            beat_s  = BEAT_ZERO;
                            valid_s = 1'b0;
                            last_s  = 1'b0;
                            ready_s = 1'b1;
                        end else begin
                            // The next beat is captured at the handshake edge
                            // even if a bubble cycle follows.
                            beat_s  = beat_inc_s;
                            data_s  = mem_r[{line_r, beat_inc_s}];
                            last_s  = (beat_inc_s == BEAT_LAST);
                            valid_s = ~BUBBLE;
                        end
                    end else begin
                        // Stalled: hold the presented beat.
                        valid_s = 1'b1;
                    end
                end else begin
                    // Bubble cycle over, present the already-loaded beat.
                    valid_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                beat_s  = BEAT_ZERO;
                lat_s   = 4'd0;
                valid_s = 1'b0;
                last_s  = 1'b0;
                ready_s = 1'b0;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            beat_r  <= BEAT_ZERO;
            lat_r   <= 4'd0;
            line_r  <= '0;
            data_r  <= 32'h0000_0000;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            beat_r  <= beat_s;
            lat_r   <= lat_s;
            line_r  <= line_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            last_r  <= last_s;
            ready_r <= ready_s;
        end
    end

    // Preload write port; storage contents survive reset
    always_ff @(posedge clk) begin
        if (init_wen) begin
            mem_r[init_addr] <= init_wdata;
        end
    end

    assign to_cache_rd_req_ready = ready_r;
    assign to_cache_rd_rsp_valid = valid_r;
    assign to_cache_rd_rsp_data  = data_r;
    assign to_cache_rd_rsp_last  = last_r;

endmodule

// File: tb/tb_burst_rd_responder.sv
// Self-checking bench for burst_rd_responder (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_burst_rd_responder;

    localparam int LAT   = 2;
    localparam int BLEN  = 8;
    localparam int DEPTH = 1024;
`ifdef BURST_BUBBLE_EN
    localparam int EXP_GAP = BLEN - 1;
`else
    localparam int EXP_GAP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_ready = 1'b1;
    logic        init_wen = 1'b0;
    logic [9:0]  init_addr = 10'h0;
    logic [31:0] init_wdata = 32'h0;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] got [BLEN];

    typedef struct {
        logic [31:0] addr;
        int          stall_beat;
        int          stall_len;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs [7];

    burst_rd_responder #(.MEM_AW(10), .BURST_LEN(BLEN), .REQ_LATENCY(LAT)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .from_cache_rd_req_valid (req_valid),
        .from_cache_rd_req_addr  (req_addr),
        .to_cache_rd_req_ready   (req_ready),
        .to_cache_rd_rsp_valid   (rsp_valid),
        .to_cache_rd_rsp_data    (rsp_data),
        .to_cache_rd_rsp_last    (rsp_last),
        .from_cache_rd_rsp_ready (rsp_ready),
        .init_wen                (init_wen),
        .init_addr               (init_addr),
        .init_wdata              (init_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] addr, input int beat);
        int unsigned line;
        line = addr >> 5;
        return int'((line * BLEN + beat) % DEPTH);
    endfunction

    task automatic mem_write(input int w, input logic [31:0] d);
        init_wen   = 1'b1;
        init_addr  = w[9:0];
        init_wdata = d;
        @(negedge clk);
        model_mem[w] = d;
        init_wen = 1'b0;
    endtask

    // One read burst. rnd: random ready and random preload writes.
    // wr_beat: while that beat is first presented, write wr_word <= wr_val.
    // abort_beat: assert reset while that beat is presented.
    task automatic run_burst(input logic [31:0] addr, input int stall_beat, input int stall_len,
                             input bit rnd, input int wr_beat, input int wr_word,
                             input logic [31:0] wr_val, input int abort_beat);
        int          beat, wait_n, stalled, gap, iter;
        bit          done, wr_done, rdy, hs;
        logic [31:0] exp_data;
        int          w;

        for (int i = 0; i < BLEN; i++) got[i] = 32'hx;
        init_wen = 1'b0;
        wait_n = 0;
        while (!req_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_addr  = addr;
        exp_data  = model_mem[word_of(addr, 0)];
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        check("ready_low_after_accept", 32'(req_ready), 32'd0);
        wait_n = 1;
        while (!rsp_valid && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check("first_valid_delay", 32'(wait_n), 32'(LAT + 1));
        if (!rsp_valid) return;

        beat = 0; stalled = 0; gap = 0; done = 1'b0; wr_done = 1'b0; iter = 0;
        while (!done && iter < 200) begin
            iter++;
            if (rsp_valid && beat == abort_beat) begin
                rst = 1'b1;
                rsp_ready = 1'b1;
                @(negedge clk);
                check("abort_valid", 32'(rsp_valid), 32'd0);
                check("abort_data", rsp_data, 32'h0);
                check("abort_last", 32'(rsp_last), 32'd0);
                check("abort_ready_in_reset", 32'(req_ready), 32'd0);
                rst = 1'b0;
                @(negedge clk);
                check("abort_ready_after", 32'(req_ready), 32'd1);
                repeat (3) @(negedge clk);
                check("abort_no_more_beats", 32'(rsp_valid), 32'd0);
                return;
            end
            if (rsp_valid) begin
                check($sformatf("beat%0d_data", beat), rsp_data, exp_data);
                check($sformatf("beat%0d_last", beat), 32'(rsp_last), 32'(beat == BLEN - 1));
            end else begin
                gap++;
            end
            if (rnd) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else if (rsp_valid && beat == stall_beat && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else begin
                rdy = 1'b1;
            end
            rsp_ready = rdy;
            hs = rsp_valid && rdy;
            if (hs) begin
                got[beat] = rsp_data;
                // The next beat is captured from storage as it stands before
                // any write landing on the same edge.
                if (beat < BLEN - 1) exp_data = model_mem[word_of(addr, beat + 1)];
            end
            init_wen = 1'b0;
            if (!rnd && rsp_valid && beat == wr_beat && !wr_done) begin
                wr_done = 1'b1;
                init_wen = 1'b1; init_addr = wr_word[9:0]; init_wdata = wr_val;
                model_mem[wr_word] = wr_val;
            end else if (rnd && $urandom_range(0, 4) == 0) begin
                w = $urandom_range(0, DEPTH - 1);
                init_wen = 1'b1; init_addr = w[9:0]; init_wdata = $urandom;
                model_mem[w] = init_wdata;
            end
            if (hs && beat == BLEN - 1) done = 1'b1;
            if (hs) beat++;
            @(negedge clk);
        end
        init_wen  = 1'b0;
        rsp_ready = 1'b1;
        if (!done) begin
            check("burst_timeout", 32'd0, 32'd1);
            return;
        end
        check("post_burst_valid", 32'(rsp_valid), 32'd0);
        check("post_burst_req_ready", 32'(req_ready), 32'd1);
        check("bubble_cycles", 32'(gap), 32'(EXP_GAP));
    endtask

    initial begin
        vecs[0] = '{32'h0000_0100, -1, 0, 32'hA000_0000, 32'hA000_0007};
        vecs[1] = '{32'h0000_011C, -1, 0, 32'hA000_0000, 32'hA000_0007};
        vecs[2] = '{32'h0000_0100,  2, 3, 32'hA000_0000, 32'hA000_0007};
        vecs[3] = '{32'h0000_1100, -1, 0, 32'hA000_0000, 32'hA000_0007};
        vecs[4] = '{32'h0000_0FE0, -1, 0, 32'h5000_03F8, 32'h5000_03FF};
        vecs[5] = '{32'hFFFF_FFE4,  7, 2, 32'h5000_03F8, 32'h5000_03FF};
        vecs[6] = '{32'h0000_0020,  0, 1, 32'h5000_0008, 32'h5000_000F};

        // Reset state
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_valid", 32'(rsp_valid), 32'd0);
        check("reset_last", 32'(rsp_last), 32'd0);
        check("reset_data", rsp_data, 32'h0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("req_ready_after_reset", 32'(req_ready), 32'd1);

        // Preload: background pattern, then the refill line at words 0x40..0x47
        for (int w = 0; w < DEPTH; w++) mem_write(w, 32'h5000_0000 + 32'(w));
        for (int i = 0; i < BLEN; i++) mem_write(32'h40 + i, 32'hA000_0000 + 32'(i));

        // Table-driven bursts
        for (int v = 0; v < 7; v++) begin
            run_burst(vecs[v].addr, vecs[v].stall_beat, vecs[v].stall_len, 1'b0, -1, 0, 32'h0, -1);
            check($sformatf("vec%0d_first", v), got[0], vecs[v].exp_first);
            check($sformatf("vec%0d_last", v), got[BLEN-1], vecs[v].exp_last);
        end

        // Write to a not-yet-loaded word while beat 2 is presented
        run_burst(32'h0000_0100, -1, 0, 1'b0, 2, 32'h46, 32'hDEAD_BEEF, -1);
        check("late_write_beat6", got[6], 32'hDEAD_BEEF);
        check("late_write_beat2", got[2], 32'hA000_0002);

        // Write colliding with the load of beat 3 returns old data this burst
        run_burst(32'h0000_0100, -1, 0, 1'b0, 2, 32'h43, 32'h1234_5678, -1);
        check("collide_beat3_old", got[3], 32'hA000_0003);
        run_burst(32'h0000_0100, -1, 0, 1'b0, -1, 0, 32'h0, -1);
        check("collide_beat3_new", got[3], 32'h1234_5678);

        // Reset during beat 4, then a fresh full burst
        run_burst(32'h0000_0100, -1, 0, 1'b0, -1, 0, 32'h0, 4);
        run_burst(32'h0000_0100, -1, 0, 1'b0, -1, 0, 32'h0, -1);
        check("after_abort_beat0", got[0], 32'hA000_0000);
        check("after_abort_beat7", got[7], 32'hA000_0007);

        // Randomized bursts against the storage model
        for (int n = 0; n < 25; n++) begin
            run_burst($urandom, -1, 0, 1'b1, -1, 0, 32'h0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
